// File: rtl/toggle_handshake_rx_if.sv
// Bundle of the toggle-handshake receiver signals.
// The slave modport is the receiver itself. The master modport is the
// environment: the toggle sender together with the stream consumer.
interface toggle_handshake_rx_if #(
    parameter int DATA_W = 6
);
    logic              req_tgl;
    logic [DATA_W-1:0] req_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              ack_tgl;
    logic              overrun;
    logic [7:0]        evt_count;

    modport master (
        output req_tgl,
        output req_data,
        output out_ready,
        input  out_valid,
        input  out_data,
        input  ack_tgl,
        input  overrun,
        input  evt_count
    );

    modport slave (
        input  req_tgl,
        input  req_data,
        input  out_ready,
        output out_valid,
        output out_data,
        output ack_tgl,
        output overrun,
        output evt_count
    );
endinterface

// File: rtl/toggle_handshake_rx.sv
// toggle_handshake_rx: receiving end of a two-phase (toggle) handshake.
//
// How it works:
// - The asynchronous req_tgl is synchronised through SYNC_STAGES flops.
// - Every level change becomes one word on a valid/ready stream.
// - ack_tgl toggles once for each consumed word.
// - A toggle that arrives while a word is still pending sets the sticky
//   overrun flag, and that new word is discarded.
//
// Optional feature: define TOGGLE_HANDSHAKE_RX_COUNT_EN to build the 8-bit
// accepted-event counter. Without it, evt_count is tied to 8'h00.
module toggle_handshake_rx #(
    parameter int SYNC_STAGES = 2,   // legal range 2..4
    parameter int DATA_W      = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    toggle_handshake_rx_if.slave  bus
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_VALID = 1'b1
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_q;
    logic                   sync_out_s;
    logic                   evt_s;
    logic                   hs_s;

    state_e                 state_q;
    state_e                 state_d;
    logic                   valid_q;
    logic                   valid_d;
    logic [DATA_W-1:0]      data_q;
    logic [DATA_W-1:0]      data_d;
    logic                   ack_q;
    logic                   ack_d;
    logic                   ovr_q;
    logic                   ovr_d;

    // Synchroniser tap and event detection. Every event is consumed by the
    // last-level register, even one that is then dropped as an overrun.
    assign sync_out_s = sync_q[SYNC_STAGES-1];
    assign evt_s      = sync_out_s ^ last_q;
    assign hs_s       = valid_q & bus.out_ready;

    // Synchroniser chain plus last-level register.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            last_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.req_tgl};
            last_q <= sync_out_s;
        end
    end

    // Next-state logic for the capture/handshake FSM and its registered outputs.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        data_d  = data_q;
        ack_d   = ack_q;
        ovr_d   = ovr_q;
        case (state_q)
            ST_IDLE: begin
                if (evt_s) begin
                    state_d = ST_VALID;
                    valid_d = 1'b1;
                    data_d  = bus.req_data;
                end else begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end
            end
            ST_VALID: begin
                if (hs_s) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                    ack_d   = ~ack_q;
                end else begin
                    state_d = ST_VALID;
                    valid_d = 1'b1;
                end
                // The sender toggled before seeing our ack. Keep the held word
                // and drop the new one.
                if (evt_s) begin
                    ovr_d = 1'b1;
                end else begin
                    ovr_d = ovr_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // FSM state and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            data_q  <= '0;
            ack_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
            ovr_q   <= ovr_d;
        end
    end

`ifdef TOGGLE_HANDSHAKE_RX_COUNT_EN
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic       cnt_inc_s;

    // Only events that are captured are counted. Overruns leave the count alone.
    assign cnt_inc_s = (state_q == ST_IDLE) & evt_s;

    // Next count; wraps naturally from 255 to 0.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_inc_s) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Event counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 8'h00;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.evt_count = cnt_q;
`else
    assign bus.evt_count = 8'h00;
`endif

    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.ack_tgl   = ack_q;
    assign bus.overrun   = ovr_q;

endmodule

// File: tb/tb_toggle_handshake_rx.sv
// Self-checking bench for toggle_handshake_rx.
// The reference model works at the event level:
// - a req_tgl level change sampled at edge k is delivered at edge k+S;
// - at that edge it is either captured or flagged as an overrun.
module tb_toggle_handshake_rx;

    localparam int S  = 2;
    localparam int DW = 6;
`ifdef TOGGLE_HANDSHAKE_RX_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    toggle_handshake_rx_if #(.DATA_W(DW)) bus();

    toggle_handshake_rx #(.SYNC_STAGES(S), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state.
    bit          m_valid;
    bit          m_ack;
    bit          m_ovr;
    logic [DW-1:0] m_data;
    int          m_events;
    bit          m_prev;
    int          edge_no = 0;
    int          arrive_q[$];
    bit          lvl;

    logic [16:0] dut_vec;
    assign dut_vec = {bus.out_valid, bus.out_data, bus.ack_tgl, bus.overrun, bus.evt_count};

    function automatic logic [16:0] exp_vec();
        logic [7:0] c;
        c = CNT_EN ? m_events[7:0] : 8'h00;
        return {m_valid, m_data, m_ack, m_ovr, c};
    endfunction

    // Drive the inputs for one edge, advance the model across that edge,
    // and return 1 time unit after the edge.
    task automatic tick(input bit r, input bit t, input logic [DW-1:0] d, input bit rdy);
        bit evt;
        rst           = r;
        bus.req_tgl   = t;
        bus.req_data  = d;
        bus.out_ready = rdy;
        if (r) begin
            m_valid  = 1'b0;
            m_ack    = 1'b0;
            m_ovr    = 1'b0;
            m_data   = '0;
            m_events = 0;
            m_prev   = 1'b0;
            arrive_q.delete();
        end else begin
            evt = 1'b0;
            if (arrive_q.size() > 0 && arrive_q[0] == edge_no) begin
                evt = 1'b1;
                void'(arrive_q.pop_front());
            end
            if (m_valid) begin
                if (rdy) begin
                    m_ack   = ~m_ack;
                    m_valid = 1'b0;
                end
                if (evt) m_ovr = 1'b1;
            end else if (evt) begin
                m_valid  = 1'b1;
                m_data   = d;
                m_events = m_events + 1;
            end
            if (t != m_prev) arrive_q.push_back(edge_no + S);
            m_prev = t;
        end
        edge_no++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        lvl = 1'b0;
        tick(1'b1, 1'b0, 6'h00, 1'b0);
        tick(1'b1, 1'b0, 6'h00, 1'b0);
        total++;
        if (dut_vec !== 17'd0) begin
            bad++;
            $display("FAIL reset_state: got %h want %h", dut_vec, 17'd0);
        end
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 1'b0, 6'($urandom), 1'($urandom_range(0, 1)));
            total++;
            if (dut_vec !== 17'd0) begin
                bad++;
                $display("FAIL reset_idle[%0d]: got %h want %h", i, dut_vec, 17'd0);
            end
        end
    endtask

    task automatic test_single();
        lvl = 1'b1;
        tick(1'b0, lvl, 6'h2A, 1'b1);
        tick(1'b0, lvl, 6'h2A, 1'b1);
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_early: valid got %b want 0", bus.out_valid);
        end
        tick(1'b0, lvl, 6'h2A, 1'b1);
        total++;
        if ({bus.out_valid, bus.out_data, bus.ack_tgl} !== {1'b1, 6'h2A, 1'b0}) begin
            bad++;
            $display("FAIL single_capture: got v=%b d=%h a=%b want v=1 d=2a a=0",
                     bus.out_valid, bus.out_data, bus.ack_tgl);
        end
        tick(1'b0, lvl, 6'h2A, 1'b1);
        total++;
        if ({bus.out_valid, bus.ack_tgl} !== 2'b01) begin
            bad++;
            $display("FAIL single_ack: got v=%b a=%b want v=0 a=1", bus.out_valid, bus.ack_tgl);
        end
        total++;
        if (bus.evt_count !== (CNT_EN ? 8'd1 : 8'd0)) begin
            bad++;
            $display("FAIL single_count: got %0d want %0d", bus.evt_count, CNT_EN ? 1 : 0);
        end
        total++;
        if (dut_vec !== exp_vec()) begin
            bad++;
            $display("FAIL single_model: got %h want %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_back_pressure();
        logic [DW-1:0] words [2];
        int n;
        words[0] = 6'h15;
        words[1] = 6'h33;
        for (int w = 0; w < 2; w++) begin
            lvl = ~lvl;
            tick(1'b0, lvl, words[w], 1'b0);
            n = 0;
            while (bus.out_valid !== 1'b1 && n < 8) begin
                tick(1'b0, lvl, words[w], 1'b0);
                n++;
            end
            total++;
            if (n != S) begin
                bad++;
                $display("FAIL bp_latency[%0d]: got %0d extra edges want %0d", w, n, S);
            end
            for (int i = 0; i < 5; i++) begin
                tick(1'b0, lvl, words[w], 1'b0);
                total++;
                if ({bus.out_valid, bus.out_data, bus.ack_tgl} !== {1'b1, words[w], (w == 0) ? 1'b1 : 1'b0}) begin
                    bad++;
                    $display("FAIL bp_hold[%0d.%0d]: got v=%b d=%h a=%b want v=1 d=%h a=%b", w, i,
                             bus.out_valid, bus.out_data, bus.ack_tgl, words[w], (w == 0) ? 1'b1 : 1'b0);
                end
            end
            tick(1'b0, lvl, words[w], 1'b1);
            total++;
            if ({bus.out_valid, bus.ack_tgl} !== {1'b0, (w == 0) ? 1'b0 : 1'b1}) begin
                bad++;
                $display("FAIL bp_release[%0d]: got v=%b a=%b want v=0 a=%b", w,
                         bus.out_valid, bus.ack_tgl, (w == 0) ? 1'b0 : 1'b1);
            end
            total++;
            if (bus.evt_count !== (CNT_EN ? 8'(2 + w) : 8'd0)) begin
                bad++;
                $display("FAIL bp_count[%0d]: got %0d want %0d", w, bus.evt_count, CNT_EN ? 2 + w : 0);
            end
        end
    endtask

    task automatic test_overrun();
        lvl = ~lvl;
        for (int i = 0; i < 3; i++) tick(1'b0, lvl, 6'h0C, 1'b0);
        lvl = ~lvl;
        for (int i = 0; i < 3; i++) tick(1'b0, lvl, 6'h3F, 1'b0);
        total++;
        if ({bus.out_valid, bus.out_data, bus.overrun} !== {1'b1, 6'h0C, 1'b1}) begin
            bad++;
            $display("FAIL overrun_flag: got v=%b d=%h o=%b want v=1 d=0c o=1",
                     bus.out_valid, bus.out_data, bus.overrun);
        end
        total++;
        if (bus.evt_count !== (CNT_EN ? 8'd4 : 8'd0)) begin
            bad++;
            $display("FAIL overrun_count: got %0d want %0d", bus.evt_count, CNT_EN ? 4 : 0);
        end
        tick(1'b0, lvl, 6'h3F, 1'b1);
        total++;
        if ({bus.out_valid, bus.ack_tgl, bus.overrun} !== 3'b001) begin
            bad++;
            $display("FAIL overrun_hs: got v=%b a=%b o=%b want v=0 a=0 o=1",
                     bus.out_valid, bus.ack_tgl, bus.overrun);
        end
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, lvl, 6'($urandom), 1'b1);
            total++;
            if (dut_vec !== exp_vec() || bus.overrun !== 1'b1) begin
                bad++;
                $display("FAIL overrun_sticky[%0d]: got %h want %h", i, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        tick(1'b1, 1'b0, 6'h00, 1'b0);
        lvl = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 4) == 0) lvl = ~lvl;
            tick(1'b0, lvl, 6'($urandom), 1'($urandom_range(0, 1)));
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++;
                $display("FAIL random[%0d]: got %h want %h", i, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_wrap();
        logic [DW-1:0] d;
        int n;
        tick(1'b1, 1'b0, 6'h00, 1'b1);
        lvl = 1'b0;
        for (int e = 0; e < 256; e++) begin
            lvl = ~lvl;
            d   = 6'($urandom);
            tick(1'b0, lvl, d, 1'b1);
            n = 0;
            while (bus.ack_tgl !== lvl && n < 10) begin
                tick(1'b0, lvl, d, 1'b1);
                n++;
                total++;
                if (dut_vec !== exp_vec()) begin
                    bad++;
                    $display("FAIL wrap_track[%0d]: got %h want %h", e, dut_vec, exp_vec());
                end
            end
            if (n >= 10) begin
                total++;
                bad++;
                $display("FAIL wrap_timeout[%0d]: ack got %b want %b", e, bus.ack_tgl, lvl);
            end
            if (e == 254) begin
                total++;
                if (bus.evt_count !== (CNT_EN ? 8'hFF : 8'h00)) begin
                    bad++;
                    $display("FAIL wrap_255: got %0d want %0d", bus.evt_count, CNT_EN ? 255 : 0);
                end
            end
        end
        total++;
        if (bus.evt_count !== 8'h00) begin
            bad++;
            $display("FAIL wrap_zero: got %0d want 0", bus.evt_count);
        end
    endtask

    task automatic test_reset_mid();
        lvl = ~lvl;
        for (int i = 0; i < 3; i++) tick(1'b0, lvl, 6'h1B, 1'b0);
        total++;
        if (bus.out_valid !== 1'b1) begin
            bad++;
            $display("FAIL mid_valid: got %b want 1", bus.out_valid);
        end
        tick(1'b1, 1'b0, 6'h1B, 1'b1);
        total++;
        if (dut_vec !== 17'd0) begin
            bad++;
            $display("FAIL mid_reset: got %h want %h", dut_vec, 17'd0);
        end
        // Sender still high while reset releases: exactly one event follows.
        tick(1'b1, 1'b1, 6'h26, 1'b0);
        tick(1'b0, 1'b1, 6'h26, 1'b0);
        tick(1'b0, 1'b1, 6'h26, 1'b0);
        total++;
        if ({bus.out_valid, bus.ack_tgl} !== 2'b00) begin
            bad++;
            $display("FAIL mid_noack: got v=%b a=%b want v=0 a=0", bus.out_valid, bus.ack_tgl);
        end
        tick(1'b0, 1'b1, 6'h26, 1'b0);
        total++;
        if ({bus.out_valid, bus.out_data} !== {1'b1, 6'h26}) begin
            bad++;
            $display("FAIL mid_release_evt: got v=%b d=%h want v=1 d=26", bus.out_valid, bus.out_data);
        end
        tick(1'b0, 1'b1, 6'h26, 1'b1);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 6'h26, 1'b1);
        total++;
        if (dut_vec !== exp_vec() || bus.ack_tgl !== 1'b1) begin
            bad++;
            $display("FAIL mid_final: got %h want %h", dut_vec, exp_vec());
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.req_tgl   = 1'b0;
        bus.req_data  = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_single();
        test_back_pressure();
        test_overrun();
        test_random();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/toggle_handshake_rx.md
# toggle_handshake_rx

Receiving end of the two-phase (toggle) handshake driven by our T flip-flop senders. It synchronises an asynchronous request toggle, turns each toggle edge (0->1 or 1->0) into one captured data word on a valid/ready output stream, and returns a toggle acknowledge once the word is consumed. It sits between an off-domain toggle source (ui_in pins or another clock domain) and synchronous logic inside the tile.

## Interface
- SYNC_STAGES, 2, flip-flop depth of the req_tgl synchroniser; legal range 2..4
- DATA_W, 6, width of the bundled data word

- clk  in  1  clock; all state on the rising edge
- rst  in  1  reset, synchronous, active-high
- req_tgl  in  1  asynchronous request toggle; every level change is one event
- req_data  in  DATA_W  bundled data; sender holds it stable from its toggle until ack_tgl changes
- out_valid  out  1  captured word available
- out_ready  in  1  consumer accepts the word when out_valid is also 1
- out_data  out  DATA_W  captured word; stable while out_valid=1
- ack_tgl  out  1  acknowledge toggle; changes level once per consumed word
- overrun  out  1  sticky protocol-violation flag
- evt_count  out  8  count of accepted events (see Configuration)

## Operation
- Synchroniser: SYNC_STAGES-deep chain on req_tgl, plus a last-level register. Event detect is high when the synchroniser output differs from the last level; the last level then updates to the synchroniser output.
- FSM states:
  - IDLE: out_valid=0. On event detect: capture req_data into out_data, go to VALID, increment evt_count.
  - VALID: out_valid=1. On out_valid&&out_ready: toggle ack_tgl, go to IDLE.
- Event detect while in VALID is a protocol violation, because the sender toggled before ack. Required response:
  - set overrun;
  - leave out_data unchanged and discard the new word;
  - leave evt_count unchanged;
  - still consume the edge by updating the last level.
- Event detect and handshake on the same edge while in VALID: the handshake completes, ack_tgl toggles, the FSM goes to IDLE, overrun is set and the new word is dropped.
- overrun clears only on rst.
- evt_count is 8-bit and wraps 255 -> 0.
- Reset (rst=1 at a clock edge) clears everything to 0: synchroniser, last level, out_valid, out_data, ack_tgl, overrun and evt_count. This holds even mid-transfer. A word held in VALID is lost and no ack is issued.
- The sender's toggle register also resets to 0. If req_tgl=1 when reset is released, one event is detected SYNC_STAGES+1 edges later. This is required behaviour.

## Timing
- Count edge E0 as the first rising edge that samples the new req_tgl level.
- The synchroniser output changes after edge E0+SYNC_STAGES-1.
- Event detect is active in the following cycle, and the capture happens at edge E0+SYNC_STAGES.
- out_valid=1 and out_data are valid immediately after edge E0+SYNC_STAGES. Latency is SYNC_STAGES+1 edges including E0; this is 3 for the default.
- When out_ready=1 is held, the handshake occurs at the next edge. out_valid falls and ack_tgl toggles at that same edge.
- Minimum round trip per word, excluding sender delay: SYNC_STAGES+2 cycles.
- A req_data change inside the synchroniser window is the sender's responsibility. No data synchroniser is provided.

## Configuration
- TOGGLE_HANDSHAKE_RX_COUNT_EN defined: the 8-bit evt_count register is built and behaves as described above.
- Not defined: no counter register. evt_count is tied to 8'h00. All other behaviour is identical.

## Test plan
- Reset: apply rst=1 for 2 cycles with req_tgl=0 -> all outputs are 0 and remain 0 for 10 idle cycles.
- Single event: req_data=6'h2A, then req_tgl 0->1, with out_ready=1 -> out_valid=1 and out_data=6'h2A 3 edges after E0. out_valid drops and ack_tgl=1 one edge later. evt_count=1.
- Back-pressure, both edges: hold out_ready=0 for 5 cycles after out_valid rises -> out_data is stable and ack_tgl is unchanged. Release -> ack toggles. A second word 6'h15 on req_tgl 1->0 -> ack_tgl returns to 0 and evt_count=2.
- Overrun: toggle req_tgl again while out_valid=1 and out_ready=0 -> overrun=1, out_data keeps its old value and evt_count is unchanged. After the handshake the FSM returns to IDLE and overrun stays 1 until rst.
- Wrap and reset mid-transfer: run 256 protocol-correct events -> evt_count=0 (with the macro) and 0 throughout (without it). Then assert rst while out_valid=1 -> outputs are 0 on the next edge and no ack toggle occurs.
